mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter: LED_INIT, 8'h00, reset value of LED register.
REQ-002 SHALL have parameter: RAM_AW, 6, RAM word-address width; RAM region is addr[7:6] != 2'b11.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port: req  in  1  CPU access strobe, held until ack.
REQ-007 SHALL have port: we  in  1  1 = write, 0 = read; valid with req.
REQ-008 SHALL have port: addr  in  8  word address from CPU ALU result.
REQ-009 SHALL have port: wdata  in  32  CPU store data.
REQ-010 SHALL have port: rdata  out  32  load data, valid on ack of a read.
REQ-011 SHALL have port: ack  out  1  one-cycle completion pulse.
REQ-012 SHALL have port: busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have port: ram_addr  out  RAM_AW  registered RAM word address.
REQ-014 SHALL have port: ram_wdata  out  32  registered RAM write data.
REQ-015 SHALL have port: ram_wren  out  1  RAM write strobe.
REQ-016 SHALL have port: ram_rden  out  1  RAM read strobe.
REQ-017 SHALL have port: ram_q  in  32  RAM read data, one clock after ram_rden.
REQ-018 SHALL have port: leds  out  8  LED register contents.

Function
REQ-019 SHALL implement FSM states IDLE, RAM_ACC, RAM_WAIT, RESP.
REQ-020 In IDLE with req=1, SHALL latch addr/we/wdata at edge N; req seen in non-IDLE states SHALL be ignored.
REQ-021 RAM read: RAM_ACC at N+1 (ram_rden=1), RAM_WAIT at N+2 (capture ram_q into rdata), RESP at N+3 (ack=1).
REQ-022 RAM write: RAM_ACC at N+1 (ram_wren=1, ram_wdata=latched wdata), RESP at N+2 (ack=1).
REQ-023 MMIO access (addr[7:6]=2'b11): RESP at N+1 with ack=1; register write takes effect at the edge ending RESP; read data is loaded into rdata on entry to RESP.
REQ-024 ram_rden and ram_wren SHALL each be high for exactly one cycle per access, never together, never for MMIO.
REQ-025 ack SHALL be high only in RESP, for exactly one cycle; FSM SHALL return to IDLE after RESP; a req still high in that IDLE cycle SHALL be accepted as a new access.
REQ-026 rdata SHALL hold its value until the next read reaches RESP; writes SHALL not change rdata.
REQ-027 ram_addr SHALL be latched addr[RAM_AW-1:0]; addr bits above RAM_AW within RAM region SHALL alias.
REQ-028 MMIO 0xC0 LED: RW; write sets leds=wdata[7:0]; read returns {24'b0, leds}.
REQ-029 MMIO 0xC1 CYCLES: RO 32-bit free-running counter, +1 every clock, wraps 32'hFFFFFFFF -> 0.
REQ-030 MMIO 0xC2 ACKS: RO 16-bit count of completed acks, wraps at 16'hFFFF -> 0; read returns zero-extended value before the current access is counted.
REQ-031 MMIO 0xC3 ERR: read returns {31'b0, err}; any write clears err.
REQ-032 A write to 0xC1 or 0xC2 SHALL not modify the register and SHALL set err=1 at the RESP edge; ack still issued.
REQ-033 If a write to 0xC3 and an error event coincide, clear SHALL win.

Reset
REQ-034 While rst_n=0, asynchronously: state=IDLE, ack=0, busy=0, ram_wren=0, ram_rden=0, rdata=0, ram_addr=0, ram_wdata=0, leds=LED_INIT, CYCLES=0, ACKS=0, err=0.
REQ-035 Reset asserted mid-access SHALL abort it with no ack and no register update; the first access after release starts from IDLE.

Verification
REQ-036 RAM write addr=8'h05, wdata=32'hDEADBEEF at N -> ram_wren=1, ram_addr=6'h05 at N+1; ack at N+2; ram_rden never high.
REQ-037 RAM read addr=8'h05 with model returning 32'hDEADBEEF -> ram_rden at N+1; ack at N+3 with rdata=32'hDEADBEEF; busy high N+1..N+3.
REQ-038 MMIO write 0xC0 wdata=32'h1A5 then read 0xC0 -> leds=8'hA5; read rdata=32'h000000A5; each ack at N+1.
REQ-039 Write 0xC1 -> err=1, CYCLES still counting; read 0xC3 -> rdata=1; write 0xC3 -> err=0.
REQ-040 Back-to-back: req held high over 3 MMIO reads -> acks exactly 2 cycles apart; ACKS read afterwards returns 3.
REQ-041 Assert rst_n=0 during RAM_WAIT -> ack never rises, all outputs at reset values immediately; new read after release completes normally.

Source files
------------

// File: rtl/mem_responder.sv
// CPU-side memory responder: routes word accesses either to an external single-port RAM
// or to a small MMIO block (LED, cycle counter, ack counter, sticky error flag).
module mem_responder #(
   parameter logic [7:0]  LED_INIT = 8'h00,
   parameter int unsigned RAM_AW   = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [7:0]        addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ack,
   output logic              busy,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              ram_wren,
   output logic              ram_rden,
   input  logic [31:0]       ram_q,
   output logic [7:0]        leds
);

   localparam logic [7:0] ADDR_LED  = 8'hC0;
   localparam logic [7:0] ADDR_CYC  = 8'hC1;
   localparam logic [7:0] ADDR_ACKS = 8'hC2;
   localparam logic [7:0] ADDR_ERR  = 8'hC3;

   typedef enum logic [1:0] {S_IDLE, S_RAM_ACC, S_RAM_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [7:0]        addr_q, addr_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              ack_q, ack_d;
   logic              busy_q, busy_d;
   logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]       ram_wdata_q, ram_wdata_d;
   logic              ram_wren_q, ram_wren_d;
   logic              ram_rden_q, ram_rden_d;
   logic [7:0]        leds_q, leds_d;
   logic [31:0]       cycles_q, cycles_d;
   logic [15:0]       acks_q, acks_d;
   logic              err_q, err_d;
   logic              err_set, err_clr;

   logic              accept_c, mmio_in_c, mmio_q_c;
   logic [31:0]       mmio_rd_c;

   assign accept_c  = (state_q == S_IDLE) && req;
   assign mmio_in_c = (addr[7:6] == 2'b11);
   assign mmio_q_c  = (addr_q[7:6] == 2'b11);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; requests outside IDLE are ignored
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (req) state_d = mmio_in_c ? S_RESP : S_RAM_ACC;
         S_RAM_ACC:  state_d = we_q ? S_RESP : S_RAM_WAIT;
         S_RAM_WAIT: state_d = S_RESP;
         S_RESP:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // MMIO read mux, sampled at the accept edge so ACKS excludes the current access
   always_comb begin
      mmio_rd_c = '0;
      case (addr)
         ADDR_LED:  mmio_rd_c = {24'b0, leds_q};
         ADDR_CYC:  mmio_rd_c = cycles_q;
         ADDR_ACKS: mmio_rd_c = {16'b0, acks_q};
         ADDR_ERR:  mmio_rd_c = {31'b0, err_q};
         default:   mmio_rd_c = '0;
      endcase
   end

   // Output and datapath next values; strobes are decoded from the next state
   always_comb begin
      we_d        = we_q;
      addr_d      = addr_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if (accept_c) begin
         we_d        = we;
         addr_d      = addr;
         ram_addr_d  = addr[RAM_AW-1:0];
         ram_wdata_d = wdata;
      end

      ack_d      = (state_d == S_RESP);
      busy_d     = (state_d != S_IDLE);
      ram_rden_d = (state_d == S_RAM_ACC) && !we_d;
      ram_wren_d = (state_d == S_RAM_ACC) && we_d;

      rdata_d = rdata_q;
      if (state_q == S_RAM_WAIT)                 rdata_d = ram_q;
      else if (accept_c && mmio_in_c && !we)     rdata_d = mmio_rd_c;

      cycles_d = cycles_q + 32'd1;
      acks_d   = acks_q;
      if (state_q == S_RESP) acks_d = acks_q + 16'd1;

      leds_d  = leds_q;
      err_set = 1'b0;
      err_clr = 1'b0;
      if (state_q == S_RESP && we_q && mmio_q_c) begin
         case (addr_q)
            ADDR_LED:           leds_d  = ram_wdata_q[7:0];
            ADDR_CYC, ADDR_ACKS: err_set = 1'b1;
            ADDR_ERR:           err_clr = 1'b1;
            default:            ;
         endcase
      end
      err_d = err_clr ? 1'b0 : (err_set ? 1'b1 : err_q);
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q        <= 1'b0;
         addr_q      <= '0;
         rdata_q     <= '0;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_wren_q  <= 1'b0;
         ram_rden_q  <= 1'b0;
         leds_q      <= LED_INIT;
         cycles_q    <= '0;
         acks_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         we_q        <= we_d;
         addr_q      <= addr_d;
         rdata_q     <= rdata_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_wren_q  <= ram_wren_d;
         ram_rden_q  <= ram_rden_d;
         leds_q      <= leds_d;
         cycles_q    <= cycles_d;
         acks_q      <= acks_d;
         err_q       <= err_d;
      end
   end

   assign rdata     = rdata_q;
   assign ack       = ack_q;
   assign busy      = busy_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_wren  = ram_wren_q;
   assign ram_rden  = ram_rden_q;
   assign leds      = leds_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: vector table, hand-written corner sequences and random
// accesses checked against an abstract memory/register model.
module tb_mem_responder;

   localparam int unsigned RAM_AW = 6;
   localparam logic [7:0]  LED_RST = 8'h3C;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req, we;
   logic [7:0]        addr;
   logic [31:0]       wdata, rdata;
   logic              ack, busy;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic              ram_wren, ram_rden;
   logic [31:0]       ram_q = '0;
   logic [7:0]        leds;

   always #5 clk = ~clk;

   mem_responder #(.LED_INIT(LED_RST), .RAM_AW(RAM_AW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .busy(busy), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_q(ram_q), .leds(leds)
   );

   // External RAM: one-clock read latency
   logic [31:0] ram_mem [64];
   always @(posedge clk) begin
      if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
      if (ram_rden) ram_q <= ram_mem[ram_addr];
   end

   // Clocks elapsed since reset release
   logic [31:0] cyc_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc_cnt <= '0;
      else        cyc_cnt <= cyc_cnt + 32'd1;
   end

   // Reference model state
   logic [31:0] m_mem [64];
   logic [7:0]  m_leds;
   logic        m_err;
   logic [15:0] m_acks;
   logic [31:0] m_rdata;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mread(input logic [7:0] a, input logic [31:0] cyc);
      if (a[7:6] != 2'b11) return m_mem[a[5:0]];
      case (a)
         8'hC0:   return {24'b0, m_leds};
         8'hC1:   return cyc;
         8'hC2:   return {16'b0, m_acks};
         8'hC3:   return {31'b0, m_err};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_leds  = LED_RST;
      m_err   = 1'b0;
      m_acks  = '0;
      m_rdata = '0;
   endtask

   // One complete access from an idle DUT, starting and ending at a falling edge
   task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic use_exp, input logic [31:0] exp_rd);
      logic        mmio, got;
      logic [31:0] exp;
      int          lat, exp_lat, rd_n, wr_n, both_n, idle_n;
      mmio = (a[7:6] == 2'b11);
      exp_lat = mmio ? 1 : (w ? 2 : 3);
      exp = w ? m_rdata : (use_exp ? exp_rd : mread(a, cyc_cnt));
      chk("leds_pre", 32'(leds), 32'(m_leds));
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk);
      got = 1'b0; lat = 0; rd_n = 0; wr_n = 0; both_n = 0; idle_n = 0;
      for (int k = 1; k <= 8 && !got; k++) begin
         @(negedge clk);
         if (ram_rden) rd_n++;
         if (ram_wren) wr_n++;
         if (ram_rden && ram_wren) both_n++;
         if (!busy) idle_n++;
         if (k == 1 && !mmio) chk("ram_addr", 32'(ram_addr), 32'(a[5:0]));
         if (k == 1 && !mmio && w) chk("ram_wdata", ram_wdata, d);
         if (ack) begin got = 1'b1; lat = k; end
      end
      req = 1'b0;
      if (!got) chk("ack_timeout", 32'd0, 32'd1);
      else      chk("ack_latency", 32'(lat), 32'(exp_lat));
      chk("rden_count", 32'(rd_n), (mmio || w) ? 32'd0 : 32'd1);
      chk("wren_count", 32'(wr_n), (!mmio && w) ? 32'd1 : 32'd0);
      chk("strobe_overlap", 32'(both_n), 32'd0);
      chk("busy_during", 32'(idle_n), 32'd0);
      chk(w ? "rdata_hold" : "rdata", rdata, exp);
      m_acks = m_acks + 16'd1;
      if (!w) m_rdata = exp;
      else if (!mmio) m_mem[a[5:0]] = d;
      else case (a)
         8'hC0:        m_leds = d[7:0];
         8'hC1, 8'hC2: m_err = 1'b1;
         8'hC3:        m_err = 1'b0;
         default:      ;
      endcase
      @(negedge clk);
      chk("ack_pulse", 32'(ack), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic        w;
      logic [7:0]  a;
      logic [31:0] d;
      logic        use_exp;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [16];
   int   ack_t [3];
   int   n_ack;

   initial begin
      for (int i = 0; i < 64; i++) begin ram_mem[i] = '0; m_mem[i] = '0; end
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rden", 32'(ram_rden), 32'd0);
      chk("rst_wren", 32'(ram_wren), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
      chk("rst_leds", 32'(leds), 32'(LED_RST));
      rst_n = 1'b1;

      vecs[0]  = '{1'b1, 8'h05, 32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 8'h05, 32'h0,        1'b1, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 8'hC0, 32'h000001A5, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 8'hC0, 32'h0,        1'b1, 32'h000000A5};
      vecs[4]  = '{1'b1, 8'hC1, 32'h00000005, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, 8'hC3, 32'h0,        1'b1, 32'h00000001};
      vecs[6]  = '{1'b1, 8'hC3, 32'h0,        1'b0, 32'h0};
      vecs[7]  = '{1'b0, 8'hC3, 32'h0,        1'b1, 32'h00000000};
      vecs[8]  = '{1'b1, 8'h45, 32'h12345678, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, 8'h05, 32'h0,        1'b1, 32'h12345678};
      vecs[10] = '{1'b0, 8'h85, 32'h0,        1'b1, 32'h12345678};
      vecs[11] = '{1'b1, 8'hC2, 32'hFFFF0000, 1'b0, 32'h0};
      vecs[12] = '{1'b0, 8'hC3, 32'h0,        1'b1, 32'h00000001};
      vecs[13] = '{1'b0, 8'hC2, 32'h0,        1'b1, 32'h0000000D};
      vecs[14] = '{1'b1, 8'hFF, 32'hFFFFFFFF, 1'b0, 32'h0};
      vecs[15] = '{1'b0, 8'hFF, 32'h0,        1'b1, 32'h00000000};
      for (int i = 0; i < 16; i++)
         access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].use_exp, vecs[i].exp_rd);
      chk("leds_after_table", 32'(leds), 32'h000000A5);

      // Cycle counter keeps running after a rejected write
      access(1'b0, 8'hC1, 32'h0, 1'b0, 32'h0);

      // Held request over three MMIO reads
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      req = 1'b1; we = 1'b0; addr = 8'hC0; wdata = '0;
      n_ack = 0;
      for (int k = 0; k < 12 && n_ack < 3; k++) begin
         @(negedge clk);
         if (ack) begin
            ack_t[n_ack] = k;
            chk("b2b_rdata", rdata, 32'(LED_RST));
            n_ack++;
         end
      end
      req = 1'b0;
      chk("b2b_ack_count", 32'(n_ack), 32'd3);
      if (n_ack == 3) begin
         chk("b2b_gap1", 32'(ack_t[1] - ack_t[0]), 32'd2);
         chk("b2b_gap2", 32'(ack_t[2] - ack_t[1]), 32'd2);
      end
      m_acks = 16'(n_ack);
      m_rdata = 32'(LED_RST);
      @(negedge clk);
      access(1'b0, 8'hC2, 32'h0, 1'b1, 32'h00000003);

      // Reset during RAM_WAIT
      access(1'b1, 8'h05, 32'hCAFEF00D, 1'b0, 32'h0);
      access(1'b1, 8'hC0, 32'h0000005A, 1'b0, 32'h0);
      req = 1'b1; we = 1'b0; addr = 8'h05;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ack", 32'(ack), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rden", 32'(ram_rden), 32'd0);
      chk("abort_rdata", rdata, 32'd0);
      chk("abort_ram_addr", 32'(ram_addr), 32'd0);
      chk("abort_leds", 32'(leds), 32'(LED_RST));
      req = 1'b0;
      n_ack = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (ack) n_ack++;
      end
      chk("abort_no_ack", 32'(n_ack), 32'd0);
      rst_n = 1'b1;
      model_reset();
      access(1'b0, 8'h05, 32'h0, 1'b1, 32'hCAFEF00D);
      access(1'b0, 8'hC2, 32'h0, 1'b1, 32'h00000001);

      // Random traffic against the model
      for (int i = 0; i < 120; i++) begin
         logic [7:0] ra;
         case ($urandom_range(0, 3))
            0, 1:    ra = 8'($urandom_range(0, 191));
            2:       ra = 8'hC0 + 8'($urandom_range(0, 3));
            default: ra = 8'($urandom_range(192, 255));
         endcase
         access(1'($urandom_range(0, 1)), ra, $urandom, 1'b0, 32'h0);
      end
      access(1'b0, 8'hC3, 32'h0, 1'b0, 32'h0);
      access(1'b0, 8'hC1, 32'h0, 1'b0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
